// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the single-port SRAM arbiter.
//   size_e : data access size encoding (matches the d_size port)
//   own_e  : owner tag of the response that is due in the next cycle
//   SRAM_AW, WORD_BYTES : SRAM word-address width and byte lanes per word
package sram_arb_pkg;

  localparam int SRAM_AW    = 14;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2,
    RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IF   = 2'd1,
    DL   = 2'd2,
    DERR = 2'd3
  } own_e;

endpackage

// File: rtl/sram_arb_if.sv
// sram_arb_if: bundles the fetch port, the load/store port and the SRAM
// macro pins seen by the arbiter.
//   master : environment side (core requesters plus the SRAM macro, which
//            drives m_rd)
//   slave  : arbiter side (grants, responses and SRAM control pins)
// Parameters: AW = SRAM word-address width, DW = data width (32).
interface sram_arb_if #(
  parameter int AW = 14,
  parameter int DW = 32
);

  logic          i_req;
  logic [AW+1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_wr;
  logic [1:0]    d_size;
  logic [AW+1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          d_err;

  logic          m_e;
  logic [3:0]    m_we;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] m_rd;

  modport master (
    output i_req, i_addr, d_req, d_wr, d_size, d_addr, d_wdata, m_rd,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           m_e, m_we, m_a, m_wd
  );

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_size, d_addr, d_wdata, m_rd,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           m_e, m_we, m_a, m_wd
  );

endinterface

// File: rtl/sram_arb_lane.sv
// sram_arb_lane: combinational byte/halfword lane steering for the data port.
//   d_wr    in  : 1 = store, 0 = load
//   d_size  in  : access size (size_e encoding)
//   addr_lo in  : byte offset within the word (d_addr[1:0])
//   d_wdata in  : LSB-aligned store data
//   we      out : SRAM byte write strobes (zero for loads and misaligned)
//   wd      out : store data replicated across all candidate lanes
//   misal   out : access is misaligned or uses the reserved size
module sram_arb_lane
  import sram_arb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                  d_wr,
  input  logic [1:0]            d_size,
  input  logic [1:0]            addr_lo,
  input  logic [DW-1:0]         d_wdata,
  output logic [WORD_BYTES-1:0] we,
  output logic [DW-1:0]         wd,
  output logic                  misal
);

  size_e sz;
  assign sz = size_e'(d_size);

  function automatic logic is_misaligned(input size_e s, input logic [1:0] lo);
    case (s)
      HALF:    return lo[0];
      WORD:    return lo != 2'b00;
      RSVD:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Data is replicated so the strobes alone select the target lane; the
  // SRAM never needs a shifter on the write path.
  always_comb begin
    we    = '0;
    wd    = d_wdata;
    misal = is_misaligned(sz, addr_lo);
    case (sz)
      BYTE: begin
        wd = {WORD_BYTES{d_wdata[7:0]}};
        we = 4'b0001 << addr_lo;
      end
      HALF: begin
        wd = {2{d_wdata[15:0]}};
        we = 4'b0011 << {addr_lo[1], 1'b0};
      end
      WORD:    we = 4'b1111;
      default: we = '0;
    endcase
    if (!d_wr || misal) we = '0;
  end

endmodule

// File: rtl/sram_arb.sv
// sram_arb: shares one single-port 32-bit byte-lane SRAM between the
// instruction-fetch port and the load/store port of the core.
//   clk  in : rising-edge clock
//   rst  in : synchronous active-high reset
//   bus     : sram_arb_if.slave (fetch port, data port, SRAM pins)
// Grants are combinational and same-cycle; read data returns one cycle
// later, steered to the owner recorded in rsp_own. Data wins over fetch.
// Optional macro SRAM_ARB_STARVE_EN adds a starvation counter that forces a
// fetch grant after STARVE_MAX consecutive denied fetch cycles.
module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int AW         = SRAM_AW,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic      clk,
  input  logic      rst,
  sram_arb_if.slave bus
);

  logic [WORD_BYTES-1:0] lane_we;
  logic [DW-1:0]         lane_wd;
  logic                  d_misal;
  logic                  fetch_force;
  own_e                  rsp_own;
  own_e                  own_next;

  // Word address only; the byte offset of a fetch carries no information.
  logic unused_ok;
  assign unused_ok = ^{bus.i_addr[1:0], (STARVE_MAX != 0)};

  sram_arb_lane #(.DW(DW)) u_lane (
    .d_wr    (bus.d_wr),
    .d_size  (bus.d_size),
    .addr_lo (bus.d_addr[1:0]),
    .d_wdata (bus.d_wdata),
    .we      (lane_we),
    .wd      (lane_wd),
    .misal   (d_misal)
  );

`ifdef SRAM_ARB_STARVE_EN
  logic [2:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (rst || bus.i_gnt) starve_cnt <= '0;
    else if (bus.i_req)   starve_cnt <= starve_cnt + 3'd1;
  end

  assign fetch_force = bus.i_req && (starve_cnt == 3'(STARVE_MAX));
`else
  assign fetch_force = 1'b0;
`endif

  // A misaligned data request is still granted (consumed) but never
  // reaches the SRAM; its response is the error tag.
  always_comb begin
    bus.i_gnt = 1'b0;
    bus.d_gnt = 1'b0;
    bus.m_e   = 1'b0;
    bus.m_we  = '0;
    bus.m_a   = '0;
    bus.m_wd  = '0;
    own_next  = NONE;
    if (!rst) begin
      if (bus.d_req && !fetch_force) begin
        bus.d_gnt = 1'b1;
        if (d_misal) begin
          own_next = DERR;
        end else begin
          bus.m_e  = 1'b1;
          bus.m_a  = bus.d_addr[AW+1:2];
          bus.m_we = lane_we;
          bus.m_wd = lane_wd;
          own_next = bus.d_wr ? NONE : DL;
        end
      end else if (bus.i_req) begin
        bus.i_gnt = 1'b1;
        bus.m_e   = 1'b1;
        bus.m_a   = bus.i_addr[AW+1:2];
        own_next  = IF;
      end
    end
  end

  // ---- grant cycle -> response cycle (SRAM read latency 1) ----
  always_ff @(posedge clk) begin
    if (rst) rsp_own <= NONE;
    else     rsp_own <= own_next;
  end

  assign bus.i_rvalid = (rsp_own == IF);
  assign bus.d_rvalid = (rsp_own == DL);
  assign bus.d_err    = (rsp_own == DERR);
  assign bus.i_rdata  = (rsp_own == IF) ? bus.m_rd : '0;
  assign bus.d_rdata  = (rsp_own == DL) ? bus.m_rd : '0;

endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: directed scenarios followed by constrained-random traffic for
// sram_arb, checked every cycle against a transaction-level reference model
// (priority rule, misalignment rule, byte-lane arithmetic, word memory).
// Honours SRAM_ARB_STARVE_EN when defined for the whole build.
module tb_sram_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_arb_if #(.AW(14), .DW(32)) bus ();

  sram_arb #(.AW(14), .DW(32), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] sram    [0:16383];
  logic [31:0] ref_mem [0:16383];

  int checks = 0;
  int errors = 0;
  int exp_own = 0;            // 0 none, 1 fetch, 2 load, 3 error
  logic [31:0] exp_data = '0;
  int starve = 0;

  function automatic logic [31:0] pre(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] we);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{we[b]}};
    return m;
  endfunction

  // SRAM macro model: samples on the rising edge, read data next cycle.
  initial begin
    for (int i = 0; i < 16384; i++) sram[i] = pre(i);
    forever begin
      @(posedge clk);
      if (bus.m_e === 1'b1) begin
        if (bus.m_we == 4'b0000) bus.m_rd <= sram[bus.m_a];
        else sram[bus.m_a] = (sram[bus.m_a] & ~bmask(bus.m_we)) | (bus.m_wd & bmask(bus.m_we));
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, compare #1 later, advance the model.
  task automatic cycle(input logic r, input logic ir, input logic [15:0] ia,
                       input logic dr, input logic dw, input logic [1:0] ds,
                       input logic [15:0] da, input logic [31:0] dd,
                       input logic late_rst, output logic gi, output logic gd);
    logic eig, edg, eme, mis, frc, wr_pend;
    logic [3:0] ewe;
    logic [31:0] ewd, ndata;
    logic [13:0] ema;
    int nown, off;
    @(negedge clk);
    rst = r;
    bus.i_req = ir; bus.i_addr = ia;
    bus.d_req = dr; bus.d_wr = dw; bus.d_size = ds; bus.d_addr = da; bus.d_wdata = dd;
    #1;
    chk("i_rvalid", 32'(bus.i_rvalid), 32'(exp_own == 1));
    chk("d_rvalid", 32'(bus.d_rvalid), 32'(exp_own == 2));
    chk("d_err", 32'(bus.d_err), 32'(exp_own == 3));
    chk("i_rdata", bus.i_rdata, (exp_own == 1) ? exp_data : 32'h0);
    chk("d_rdata", bus.d_rdata, (exp_own == 2) ? exp_data : 32'h0);

    eig = 0; edg = 0; eme = 0; ewe = 0; ewd = 0; ema = 0;
    nown = 0; ndata = 0; wr_pend = 0;
    off = int'(da[1:0]);
    mis = (ds == 2'd3) || (ds == 2'd1 && da[0]) || (ds == 2'd2 && da[1:0] != 2'd0);
    frc = 1'b0;
`ifdef SRAM_ARB_STARVE_EN
    frc = ir && (starve == 4);
`endif
    if (!r) begin
      if (dr && !frc) begin
        edg = 1;
        if (mis) nown = 3;
        else begin
          eme = 1; ema = da[15:2];
          if (dw) begin
            wr_pend = 1;
            case (ds)
              2'd0: begin ewe = 4'(1 << off); ewd = 32'(dd[7:0]) * 32'h0101_0101; end
              2'd1: begin ewe = 4'(3 << (2 * (off / 2))); ewd = 32'(dd[15:0]) * 32'h0001_0001; end
              default: begin ewe = 4'hF; ewd = dd; end
            endcase
          end else begin
            nown = 2; ndata = ref_mem[int'(da[15:2])];
          end
        end
      end else if (ir) begin
        eig = 1; eme = 1; ema = ia[15:2];
        nown = 1; ndata = ref_mem[int'(ia[15:2])];
      end
    end
    chk("i_gnt", 32'(bus.i_gnt), 32'(eig));
    chk("d_gnt", 32'(bus.d_gnt), 32'(edg));
    chk("m_e", 32'(bus.m_e), 32'(eme));
    if (r || eme) begin
      chk("m_a", 32'(bus.m_a), 32'(ema));
      chk("m_we", 32'(bus.m_we), 32'(ewe));
    end
    if (r || wr_pend) chk("m_wd", bus.m_wd, ewd);

    if (late_rst) begin
      rst = 1'b1;
      #1;
      nown = 0; ndata = 0; wr_pend = 0; starve = 0;
    end else if (r || eig) starve = 0;
    else if (ir) starve++;
    if (wr_pend)
      ref_mem[int'(ema)] = (ref_mem[int'(ema)] & ~bmask(ewe)) | (ewd & bmask(ewe));
    exp_own = nown;
    exp_data = ndata;
    gi = eig;
    gd = edg;
  endtask

  initial begin
    logic gi, gd, pi, pd, pdw, rr;
    logic [15:0] pia, pda;
    logic [1:0] pds;
    logic [31:0] pdd;
    for (int i = 0; i < 16384; i++) ref_mem[i] = pre(i);
    bus.i_req = 1'b1; bus.i_addr = 16'h0004;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_size = 2'd2; bus.d_addr = 16'h0010; bus.d_wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Reset held with both requests high.
    for (int k = 0; k < 3; k++) begin
      cycle(1, 1, 16'h0004, 1, 0, 2, 16'h0010, 0, 0, gi, gd);
      chk("rst_ign", 32'(bus.i_gnt), 32'h0);
      chk("rst_dgnt", 32'(bus.d_gnt), 32'h0);
      chk("rst_me", 32'(bus.m_e), 32'h0);
    end
    cycle(0, 1, 16'h0004, 1, 0, 2, 16'h0010, 0, 0, gi, gd);
    chk("post_rst_dgnt", 32'(bus.d_gnt), 32'h1);

    // Back-to-back fetches.
    cycle(0, 1, 16'h0004, 0, 0, 0, 0, 0, 0, gi, gd);
    chk("fetch1_ma", 32'(bus.m_a), 32'h1);
    cycle(0, 1, 16'h0008, 0, 0, 0, 0, 0, 0, gi, gd);
    chk("fetch2_ma", 32'(bus.m_a), 32'h2);
    chk("fetch1_rdata", bus.i_rdata, pre(1));
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd);
    chk("fetch2_rdata", bus.i_rdata, pre(2));

    // Byte store at offset 3, then load the word back.
    cycle(0, 0, 0, 1, 1, 0, 16'h0013, 32'h0000_00A5, 0, gi, gd);
    chk("sb_we", 32'(bus.m_we), 32'h8);
    chk("sb_wd", bus.m_wd, 32'hA5A5_A5A5);
    cycle(0, 0, 0, 1, 0, 2, 16'h0010, 0, 0, gi, gd);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd);
    chk("lw_rvalid", 32'(bus.d_rvalid), 32'h1);
    chk("lw_top_byte", 32'(bus.d_rdata[31:24]), 32'hA5);

    // Misaligned halfword store competing with a fetch.
    cycle(0, 1, 16'h0000, 1, 1, 1, 16'h0021, 32'h0000_BEEF, 0, gi, gd);
    chk("mis_dgnt", 32'(bus.d_gnt), 32'h1);
    chk("mis_me", 32'(bus.m_e), 32'h0);
    chk("mis_ign", 32'(bus.i_gnt), 32'h0);
    cycle(0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, gi, gd);
    chk("mis_err", 32'(bus.d_err), 32'h1);
    chk("mis_rvalid", 32'(bus.d_rvalid), 32'h0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd);
    chk("mis_mem", sram[8], pre(8));

    // Fetch granted, reset sampled on that edge, fetch re-issued.
    cycle(0, 1, 16'h000C, 0, 0, 0, 0, 0, 1, gi, gd);
    cycle(0, 1, 16'h000C, 0, 0, 0, 0, 0, 0, gi, gd);
    chk("rstpulse_norvalid", 32'(bus.i_rvalid), 32'h0);
    chk("rstpulse_regnt", 32'(bus.i_gnt), 32'h1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd);
    chk("rstpulse_rdata", bus.i_rdata, pre(3));

    // Both requests held high continuously.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, 16'h0040, 1, 0, 2, 16'h0044, 0, 0, gi, gd);
`ifdef SRAM_ARB_STARVE_EN
      chk("starve_ign", 32'(bus.i_gnt), 32'(k == 4 || k == 9));
`else
      chk("starve_ign", 32'(bus.i_gnt), 32'h0);
`endif
    end

    // Random traffic; requesters hold until granted.
    pi = 0; pd = 0; pia = 0; pda = 0; pdw = 0; pds = 0; pdd = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!pi && $urandom_range(0, 3) != 0) begin
        pi = 1; pia = 16'($urandom_range(0, 127));
      end
      if (!pd && $urandom_range(0, 2) != 0) begin
        pd = 1; pdw = 1'($urandom_range(0, 1)); pds = 2'($urandom_range(0, 3));
        pda = 16'($urandom_range(0, 127)); pdd = $urandom;
        if ($urandom_range(0, 3) != 0)
          pda = pda & ~((pds == 2'd2) ? 16'h3 : (pds == 2'd1) ? 16'h1 : 16'h0);
      end
      rr = ($urandom_range(0, 99) == 0);
      cycle(rr, pi, pia, pd, pdw, pds, pda, pdd, 0, gi, gd);
      if (gi) pi = 0;
      if (gd) pd = 0;
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, gi, gd);
    for (int i = 0; i < 32; i++) chk("mem_final", sram[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arb.md
# sram_arb

Single-port SRAM arbiter for the RISC-V core's memory subsystem. It shares one 32-bit byte-lane SRAM (16K words) between the core's instruction-fetch port and its load/store data port. It also performs the data-port byte/halfword lane steering and misalignment checking. It sits between `core` and the SRAM macro, replacing the separate instruction/data memory paths.

## Interface
- `AW`, 14, SRAM word-address width (byte address width is AW+2).
- `DW`, 32, data width; fixed at 32, kept only for readability.
- `STARVE_MAX`, 4, consecutive denied fetch cycles before fetch is forced to win. Used only with the macro.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_req` in 1: fetch request.
- `i_addr` in 16: fetch byte address; bits [1:0] are ignored.
- `i_gnt` out 1: fetch accepted this cycle.
- `i_rvalid` out 1: fetch data valid.
- `i_rdata` out 32: fetch word.
- `d_req` in 1: data request.
- `d_wr` in 1: 1 = store, 0 = load.
- `d_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = reserved (treated as misaligned).
- `d_addr` in 16: data byte address.
- `d_wdata` in 32: store data, LSB-aligned.
- `d_gnt` out 1: data request consumed this cycle.
- `d_rvalid` out 1: load data valid.
- `d_rdata` out 32: raw load word; the core extracts the lane.
- `d_err` out 1: misaligned-access response.
- `m_e` out 1: SRAM enable.
- `m_we` out 4: SRAM byte write strobes.
- `m_a` out 14: SRAM word address.
- `m_wd` out 32: SRAM write data.
- `m_rd` in 32: SRAM read data, valid the cycle after a read enable.

## Operation
- **Arbitration:** combinational, each cycle. The default is fixed priority with data over fetch; at most one grant per cycle.
- **Request stability:** a requester holds `req` and its qualifiers stable until it sees `gnt`. The arbiter does not buffer requests.
- **Misalignment:** `d_size`=1 with `d_addr[0]`=1, `d_size`=2 with `d_addr[1:0]`≠0, or `d_size`=3.
  - `d_gnt`=1 and `m_e`=0; the request is consumed.
  - Next cycle `d_err`=1, and `d_rvalid` stays 0.
  - A misaligned data request still takes priority in that cycle, so fetch is denied.
- **Aligned data grant:** `m_e`=1 and `m_a`=`d_addr[15:2]`.
  - Load: `m_we`=0000.
  - Store, byte: `m_we`=0001<<`d_addr[1:0]`, `m_wd`={4{`d_wdata[7:0]`}}.
  - Store, half: `m_we`=0011<<(2·`d_addr[1]`), `m_wd`={2{`d_wdata[15:0]`}}.
  - Store, word: `m_we`=1111, `m_wd`=`d_wdata`.
  - Stores produce no response.
- **Fetch grant:** `m_e`=1, `m_we`=0000, `m_a`=`i_addr[15:2]`.
- **Response tag register:** `rsp_own` ∈ {NONE, IF, DL, DERR}, loaded every cycle from that cycle's grant.
  - `i_rvalid` = (`rsp_own`==IF); `d_rvalid` = (`rsp_own`==DL); `d_err` = (`rsp_own`==DERR).
  - `i_rdata`/`d_rdata` = `m_rd` when the respective rvalid is 1, else 0.
- **Reset:** while `rst`=1, all grants and `m_e` are 0, and `m_we`, `m_a`, `m_wd` are 0. On the first clock edge with `rst` high, `rsp_own` becomes NONE, so all rvalid/err outputs and rdata outputs read 0.
  - Reset mid-operation: a response due on the reset edge is dropped. Requesters re-issue after reset.

## Timing
- Grant is same-cycle as `req`; the SRAM samples on that rising edge.
- Read latency is 1: rvalid is asserted in the cycle after the grant.
- Full throughput: one access per cycle, back-to-back, mixed owners allowed.
- Simultaneous `i_req`/`d_req`: data wins, and fetch waits with `i_gnt`=0, unless the starvation override is active.
- A store followed by a load to the same word on the next cycle returns the new data (SRAM write-first ordering across cycles).

## Configuration
- `SRAM_ARB_STARVE_EN` defined:
  - A 3-bit `starve_cnt` increments on each cycle with `i_req`=1 and `i_gnt`=0, and clears on `i_gnt` or `rst`.
  - When `starve_cnt`==`STARVE_MAX`, fetch wins over data for that cycle.
- `SRAM_ARB_STARVE_EN` undefined: pure fixed priority; the counter is not present. A continuous `d_req` starves fetch indefinitely.

## Structure
- `sram_arb_pkg`:
  - `size_e` (BYTE/HALF/WORD/RSVD).
  - `own_e` (NONE/IF/DL/DERR).
  - Constants `SRAM_AW`=14 and `WORD_BYTES`=4.
- Sub-module `sram_arb_lane`: combinational generation of `m_we`, `m_wd` and the misaligned flag from `d_wr`, `d_size`, `d_addr[1:0]`, `d_wdata`.
- The top level contains the arbitration, the `rsp_own` register and the optional starvation counter.

## Test plan
- Reset held 3 cycles with both requests high → all grants, `m_e`, rvalids and `d_err` are 0. First cycle after reset → `d_gnt`=1.
- Fetch only, `i_addr`=0x0004, then 0x0008 back-to-back → `m_a`=1 then 2; `i_rvalid` on the following cycles with `i_rdata` = preloaded words.
- Store byte `d_addr`=0x0013, `d_wdata`=0x000000A5 → `m_we`=1000, `m_wd`=0xA5A5A5A5. Load word 0x0010 next → `d_rdata`[31:24]=0xA5.
- Store half at 0x0021 → `d_gnt`=1, `m_e`=0. Next cycle `d_err`=1, `d_rvalid`=0, and SRAM contents are unchanged.
- Both requests held high continuously (with macro, `STARVE_MAX`=4) → data granted 4 cycles, fetch granted on cycle 5, then data again. Without macro → `i_gnt` never asserts.
- Fetch granted, then `rst` pulsed on the next edge → no `i_rvalid`. After release, the re-issued fetch completes normally.
